// File: rtl/sc_decoder.sv
// sc_decoder: converts a stochastic bitstream back into a binary estimate.
// Each accepted word is popcounted and added to a frame accumulator. A frame
// closes on wlast or on its last beat, whichever comes first. The result is
// loaded into a one-entry output register together with a framing-error flag.
module sc_decoder #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int LOG_BEATS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [BITSTREAM-1:0]                 w_bitstream,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic                                 wlast,
  output logic [QUANT-1:0]                     r_data,
  output logic [$clog2(BITSTREAM)+LOG_BEATS:0] r_ones,
  output logic                                 r_err,
  output logic                                 r_valid,
  input  logic                                 r_ready
);

  localparam int CW      = $clog2(BITSTREAM);
  localparam int PC_W    = CW + 1;
  localparam int SUM_W   = CW + LOG_BEATS + 1;
  localparam int BW      = (LOG_BEATS > 0) ? LOG_BEATS : 1;
  localparam int SCALE_W = SUM_W + QUANT;
  localparam int SHIFT   = CW + LOG_BEATS;

  localparam logic [BW-1:0]      LAST_BEAT = BW'((1 << LOG_BEATS) - 1);
  localparam logic [SCALE_W-1:0] DATA_MAX  = SCALE_W'((1 << QUANT) - 1);

  logic [SUM_W-1:0]   r_acc;
  logic [BW-1:0]      r_beat;

  logic [PC_W-1:0]    w_pc;
  logic [SUM_W-1:0]   w_sum;
  logic [SCALE_W-1:0] w_scaled;
  logic [QUANT-1:0]   w_data;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_close;
  logic               w_frame_err;

  // Input is blocked only while a finished result is waiting to be taken.
  assign w_ready = !(r_valid && !r_ready);

  assign w_accept    = w_valid && w_ready;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_close     = w_accept && (wlast || w_last_beat);
  // wlast before the last beat is a short frame; a last beat without wlast is
  // a missing last. Either way the two disagree.
  assign w_frame_err = wlast ^ w_last_beat;

  // Popcount of the incoming word.
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < BITSTREAM; i++) begin
      w_pc = w_pc + PC_W'(w_bitstream[i]);
    end
  end

  assign w_sum = r_acc + SUM_W'(w_pc);

  // Scale the ones count to QUANT bits as if the frame were full; only an
  // all-ones frame reaches 2^QUANT and needs saturating.
  assign w_scaled = ({{QUANT{1'b0}}, w_sum} << QUANT) >> SHIFT;
  assign w_data   = (w_scaled > DATA_MAX) ? DATA_MAX[QUANT-1:0] : w_scaled[QUANT-1:0];

  // Frame accumulator and beat counter; both restart at every frame close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_beat <= '0;
    end else if (w_close) begin
      r_acc  <= '0;
      r_beat <= '0;
    end else if (w_accept) begin
      r_acc  <= w_sum;
      r_beat <= r_beat + 1'b1;
    end
  end

  // One-entry result register; a new close may overwrite a result being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ones  <= '0;
      r_err   <= 1'b0;
    end else if (w_close) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_ones  <= w_sum;
      r_err   <= w_frame_err;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
